// File: rtl/lunar_lander_core.sv
// lunar_lander_core
// Lunar-lander physics engine with an explicit flight state machine.
// Each un-held FLYING cycle advances one physics step:
//   fuel     <= fuel - min(burn, fuel)
//   velocity <= sat(velocity - GRAVITY + THRUST_GAIN*burn_eff)
//   altitude <= sat(altitude + velocity)   (old velocity)
// Touchdown (new altitude <= 0) ends the flight as LANDED or CRASHED
// depending on the impact speed.
//
// Ports:
//   clk_2        in   clock
//   reset        in   synchronous, active-low reset
//   start        in   IDLE -> FLYING request
//   hold         in   freezes the simulation while FLYING
//   burn         in   requested fuel units for this step
//   fuel         out  remaining fuel (registered)
//   velocity     out  signed velocity, positive = upward (registered)
//   altitude     out  altitude (registered)
//   state        out  0 IDLE, 1 FLYING, 2 LANDED, 3 CRASHED
//   flight_time  out  FLYING steps taken, saturating
//   landed       out  state == LANDED
//   crashed      out  state == CRASHED
//   fuel_empty   out  fuel == 0 (combinational)
module lunar_lander_core #(
    parameter int NBITS_FUEL  = 8,
    parameter int NBITS_VEL   = 12,
    parameter int NBITS_ALT   = 12,
    parameter int NBITS_BURN  = 7,
    parameter int NBITS_TIME  = 8,
    parameter int FUEL_INIT   = 120,
    parameter int VEL_INIT    = -50,
    parameter int ALT_INIT    = 500,
    parameter int GRAVITY     = 5,
    parameter int THRUST_GAIN = 1,
    parameter int SAFE_VEL    = 10
) (
    input  logic                         clk_2,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         hold,
    input  logic [NBITS_BURN-1:0]        burn,
    output logic [NBITS_FUEL-1:0]        fuel,
    output logic signed [NBITS_VEL-1:0]  velocity,
    output logic [NBITS_ALT-1:0]         altitude,
    output logic [1:0]                   state,
    output logic [NBITS_TIME-1:0]        flight_time,
    output logic                         landed,
    output logic                         crashed,
    output logic                         fuel_empty
);

    // All intermediate physics runs at this width so that the sum and the
    // thrust product can never overflow before being saturated.
    localparam int WIDE = 64;

    localparam logic signed [WIDE-1:0] VEL_MAX = (64'sd1 <<< (NBITS_VEL - 1)) - 64'sd1;
    localparam logic signed [WIDE-1:0] VEL_MIN = -(64'sd1 <<< (NBITS_VEL - 1));
    localparam logic signed [WIDE-1:0] ALT_MAX = (64'sd1 <<< NBITS_ALT) - 64'sd1;
    localparam logic signed [WIDE-1:0] SAFE_W  = WIDE'(SAFE_VEL);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FLYING  = 2'd1,
        LANDED  = 2'd2,
        CRASHED = 2'd3
    } state_t;

    state_t                        state_q;
    state_t                        state_d;
    logic [NBITS_FUEL-1:0]         fuel_d;
    logic signed [NBITS_VEL-1:0]   vel_d;
    logic [NBITS_ALT-1:0]          alt_d;
    logic [NBITS_TIME-1:0]         time_d;

    logic [NBITS_FUEL-1:0]         burn_eff;
    logic signed [WIDE-1:0]        vel_w;
    logic signed [WIDE-1:0]        burn_w;
    logic signed [WIDE-1:0]        v_sum;
    logic signed [WIDE-1:0]        a_sum;
    logic signed [NBITS_VEL-1:0]   v_sat;
    logic [NBITS_ALT-1:0]          alt_step;
    logic [NBITS_TIME-1:0]         time_inc;
    logic                          touchdown;
    logic                          impact_safe;

    // Physics datapath for one step, always computed from the current
    // register values; the FSM decides whether the result is committed.
    always_comb begin
        burn_eff = (WIDE'(burn) < WIDE'(fuel)) ? NBITS_FUEL'(burn) : fuel;

        vel_w  = WIDE'(velocity);
        burn_w = $signed(WIDE'(burn_eff));
        v_sum  = vel_w - WIDE'(GRAVITY) + WIDE'(THRUST_GAIN) * burn_w;
        a_sum  = $signed(WIDE'(altitude)) + vel_w;

        if (v_sum > VEL_MAX) begin
            v_sat = NBITS_VEL'(VEL_MAX);
        end else if (v_sum < VEL_MIN) begin
            v_sat = NBITS_VEL'(VEL_MIN);
        end else begin
            v_sat = NBITS_VEL'(v_sum);
        end

        // Only reached when a_sum is positive, so the upper clamp suffices.
        alt_step = (a_sum > ALT_MAX) ? NBITS_ALT'(ALT_MAX) : NBITS_ALT'(a_sum);

        time_inc = (flight_time == '1) ? flight_time
                                       : flight_time + NBITS_TIME'(1);

        touchdown   = (a_sum <= 64'sd0);
        impact_safe = (vel_w <= SAFE_W) && (vel_w >= -SAFE_W);
    end

    // Next-state logic: everything holds unless the FSM is flying un-held.
    // On touchdown the impact velocity and fuel are kept, no burn applied.
    always_comb begin
        state_d = state_q;
        fuel_d  = fuel;
        vel_d   = velocity;
        alt_d   = altitude;
        time_d  = flight_time;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FLYING;
                end
            end
            FLYING: begin
                if (!hold) begin
                    time_d = time_inc;
                    if (touchdown) begin
                        alt_d   = '0;
                        state_d = impact_safe ? LANDED : CRASHED;
                    end else begin
                        fuel_d = fuel - burn_eff;
                        vel_d  = v_sat;
                        alt_d  = alt_step;
                    end
                end
            end
            LANDED: begin
            end
            CRASHED: begin
            end
        endcase
    end

    // State and physics registers with synchronous active-low reset.
    always_ff @(posedge clk_2) begin
        if (!reset) begin
            state_q     <= IDLE;
            fuel        <= NBITS_FUEL'(FUEL_INIT);
            velocity    <= NBITS_VEL'(VEL_INIT);
            altitude    <= NBITS_ALT'(ALT_INIT);
            flight_time <= '0;
        end else begin
            state_q     <= state_d;
            fuel        <= fuel_d;
            velocity    <= vel_d;
            altitude    <= alt_d;
            flight_time <= time_d;
        end
    end

    assign state      = state_q;
    assign landed     = (state_q == LANDED);
    assign crashed    = (state_q == CRASHED);
    assign fuel_empty = (fuel == '0);

endmodule

// File: tb/tb_lunar_lander_core.sv
// tb_lunar_lander_core
// Drives four lunar_lander_core instances with shared inputs: the default
// configuration, two touchdown-threshold configurations and a strong-thrust
// configuration for saturation. Each instance is compared every cycle with
// an integer model of the flight rules, plus fixed expected values along
// the directed scenarios.
module tb_lunar_lander_core;

    localparam int N = 4;
    localparam int P_FUEL [N] = '{120, 120, 120, 255};
    localparam int P_VEL  [N] = '{-50, -10, -11, -50};
    localparam int P_ALT  [N] = '{500,  10,  10, 500};
    localparam int P_GRAV [N] = '{5, 5, 5, 1};
    localparam int P_THR  [N] = '{1, 1, 1, 20};
    localparam int SAFE   = 10;

    logic clk_2 = 1'b0;
    logic reset;
    logic start;
    logic hold;
    logic [6:0] burn;

    logic [7:0]          fuel_o   [N];
    logic signed [11:0]  vel_o    [N];
    logic [11:0]         alt_o    [N];
    logic [1:0]          state_o  [N];
    logic [7:0]          time_o   [N];
    logic                landed_o [N];
    logic                crashed_o[N];
    logic                empty_o  [N];

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int fuel;
        int vel;
        int alt;
        int st;
        int ft;
    } model_t;

    model_t mdl [N];

    always #5 clk_2 = ~clk_2;

    for (genvar g = 0; g < N; g++) begin : g_dut
        lunar_lander_core #(
            .FUEL_INIT   (P_FUEL[g]),
            .VEL_INIT    (P_VEL[g]),
            .ALT_INIT    (P_ALT[g]),
            .GRAVITY     (P_GRAV[g]),
            .THRUST_GAIN (P_THR[g]),
            .SAFE_VEL    (SAFE)
        ) u_dut (
            .clk_2       (clk_2),
            .reset       (reset),
            .start       (start),
            .hold        (hold),
            .burn        (burn),
            .fuel        (fuel_o[g]),
            .velocity    (vel_o[g]),
            .altitude    (alt_o[g]),
            .state       (state_o[g]),
            .flight_time (time_o[g]),
            .landed      (landed_o[g]),
            .crashed     (crashed_o[g]),
            .fuel_empty  (empty_o[g])
        );
    end

    // Flight rules in plain integer arithmetic (states: 0 idle, 1 flying,
    // 2 landed, 3 crashed).
    function automatic model_t model_step(input model_t m, input int g,
                                          input logic rst_n, input logic st_in,
                                          input logic hld, input int b);
        model_t r;
        int be;
        int an;
        int vn;
        r = m;
        if (!rst_n) begin
            r.fuel = P_FUEL[g];
            r.vel  = P_VEL[g];
            r.alt  = P_ALT[g];
            r.st   = 0;
            r.ft   = 0;
            return r;
        end
        if (m.st == 0) begin
            if (st_in) r.st = 1;
        end else if (m.st == 1 && !hld) begin
            be   = (b < m.fuel) ? b : m.fuel;
            an   = m.alt + m.vel;
            r.ft = (m.ft < 255) ? m.ft + 1 : 255;
            if (an <= 0) begin
                r.alt = 0;
                r.st  = (m.vel <= SAFE && m.vel >= -SAFE) ? 2 : 3;
            end else begin
                vn = m.vel - P_GRAV[g] + P_THR[g] * be;
                if (vn > 2047)  vn = 2047;
                if (vn < -2048) vn = -2048;
                r.fuel = m.fuel - be;
                r.vel  = vn;
                r.alt  = (an > 4095) ? 4095 : an;
            end
        end
        return r;
    endfunction

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic compareAll();
        for (int g = 0; g < N; g++) begin
            checkOutput($sformatf("fuel[%0d]", g),    int'(fuel_o[g]),    mdl[g].fuel);
            checkOutput($sformatf("vel[%0d]", g),     int'(vel_o[g]),     mdl[g].vel);
            checkOutput($sformatf("alt[%0d]", g),     int'(alt_o[g]),     mdl[g].alt);
            checkOutput($sformatf("state[%0d]", g),   int'(state_o[g]),   mdl[g].st);
            checkOutput($sformatf("time[%0d]", g),    int'(time_o[g]),    mdl[g].ft);
            checkOutput($sformatf("landed[%0d]", g),  int'(landed_o[g]),  int'(mdl[g].st == 2));
            checkOutput($sformatf("crashed[%0d]", g), int'(crashed_o[g]), int'(mdl[g].st == 3));
            checkOutput($sformatf("empty[%0d]", g),   int'(empty_o[g]),   int'(mdl[g].fuel == 0));
        end
    endtask

    // Inputs change on the falling edge; models advance on the rising edge
    // and outputs are sampled 1 time unit later.
    task automatic applyStimulus(input logic rst_n, input logic st_in,
                                 input logic hld, input int b);
        @(negedge clk_2);
        reset = rst_n;
        start = st_in;
        hold  = hld;
        burn  = 7'(b);
        @(posedge clk_2);
        for (int g = 0; g < N; g++) begin
            mdl[g] = model_step(mdl[g], g, rst_n, st_in, hld, b);
        end
        #1;
        compareAll();
    endtask

    task automatic checkMain(input string tag, input int f, input int v, input int a,
                             input int s, input int t);
        checkOutput({tag, "_fuel"},  int'(fuel_o[0]),  f);
        checkOutput({tag, "_vel"},   int'(vel_o[0]),   v);
        checkOutput({tag, "_alt"},   int'(alt_o[0]),   a);
        checkOutput({tag, "_state"}, int'(state_o[0]), s);
        checkOutput({tag, "_time"},  int'(time_o[0]),  t);
    endtask

    int ff_alt [8] = '{450, 395, 335, 270, 200, 125, 45, 0};
    int ff_vel [8] = '{-55, -60, -65, -70, -75, -80, -85, -85};

    initial begin
        reset = 1'b0;
        start = 1'b0;
        hold  = 1'b0;
        burn  = '0;

        // Reset and idle
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0);
        checkMain("reset", 120, -50, 500, 0, 0);
        applyStimulus(1, 0, 0, 0);
        checkMain("idle", 120, -50, 500, 0, 0);
        applyStimulus(1, 1, 0, 0);
        checkMain("start", 120, -50, 500, 1, 0);

        // Free fall with no burn
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1, 0, 0, 0);
            checkOutput($sformatf("ff_alt%0d", k), int'(alt_o[0]), ff_alt[k]);
            checkOutput($sformatf("ff_vel%0d", k), int'(vel_o[0]), ff_vel[k]);
        end
        checkMain("crash", 120, -85, 0, 3, 8);
        checkOutput("thr_landed", int'(state_o[1]), 2);
        checkOutput("thr_crashed", int'(state_o[2]), 3);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          int'($urandom_range(0, 127)));
        end
        checkMain("frozen", 120, -85, 0, 3, 8);

        // Burn clamped to available fuel, then hold
        applyStimulus(0, 0, 0, 0);
        applyStimulus(1, 1, 0, 0);
        applyStimulus(1, 0, 0, 127);
        checkMain("clamp1", 0, 65, 450, 1, 1);
        checkOutput("clamp1_empty", int'(empty_o[0]), 1);
        applyStimulus(1, 0, 0, 127);
        checkMain("clamp2", 0, 60, 515, 1, 2);
        applyStimulus(1, 0, 0, 3);
        applyStimulus(1, 0, 0, 3);
        checkMain("prehold", 0, 50, 630, 1, 4);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 1'($urandom_range(0, 1)), 1, int'($urandom_range(0, 127)));
        end
        checkMain("held", 0, 50, 630, 1, 4);
        applyStimulus(1, 0, 0, 0);
        checkMain("resume", 0, 45, 680, 1, 5);

        // Reset mid-flight with start held across release
        applyStimulus(0, 0, 0, 0);
        applyStimulus(1, 1, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0);
        checkMain("step3", 120, -65, 335, 1, 3);
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 1, 0, 0);
        checkMain("midrst", 120, -50, 500, 0, 0);
        applyStimulus(1, 1, 0, 0);
        checkMain("rel", 120, -50, 500, 1, 0);
        applyStimulus(1, 0, 0, 0);
        checkMain("rel_step", 120, -55, 450, 1, 1);

        // Saturation on the strong-thrust instance
        applyStimulus(0, 0, 0, 0);
        applyStimulus(1, 1, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 127);
        checkOutput("sat_vel", int'(vel_o[3]), 2047);
        checkOutput("sat_alt", int'(alt_o[3]), 4095);
        checkOutput("sat_fuel", int'(fuel_o[3]), 0);
        applyStimulus(1, 0, 0, 127);
        checkOutput("sat_vel2", int'(vel_o[3]), 2046);
        checkOutput("sat_alt2", int'(alt_o[3]), 4095);

        // Randomized flights against the model
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 39) != 0),
                          1'($urandom_range(0, 3) == 0),
                          1'($urandom_range(0, 4) == 0),
                          ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(0, 127)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
